// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: confines all framebuffer writes to vertical blanking,
// round-robin arbitrates the requesters and runs a pausable full-screen clear sweep.
module fb_write_scheduler #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned CELLS        = 4800,
  parameter int unsigned VBLANK_START = 480
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic [9:0]        vc,
  input  logic [N_REQ-1:0]  req_valid,
  input  logic [ADDR_W-1:0] req_addr [0:N_REQ-1],
  input  logic [7:0]        req_data [0:N_REQ-1],
  output logic [N_REQ-1:0]  req_ready,
  input  logic              clear_req,
  input  logic [7:0]        clear_color,
  output logic              clear_busy,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_data,
  output logic              frame_tick
);

  localparam int unsigned       PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [9:0]        VB_LINE   = 10'(VBLANK_START);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   CELLS_EXT = (ADDR_W + 1)'(CELLS);

  typedef enum logic [1:0] {StActive, StServe, StClear} state_e;

  state_e            state_q, state_d;
  logic              vblank_q;
  logic              clear_pending_q;
  logic [7:0]        clr_color_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [PTR_W-1:0]  rr_ptr_q;

  logic              in_vblank, vblank_entry, clr_write;
  logic              grant_any, grant_in_range;
  logic [PTR_W-1:0]  grant_idx, cand, rr_next;

  assign in_vblank    = (vc >= VB_LINE);
  assign vblank_entry = in_vblank && !vblank_q;
  // A sweep only writes while the sampled line is still inside blanking.
  assign clr_write    = (state_q == StClear) && in_vblank;
  assign clear_busy   = clear_pending_q;

  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (state_q == StServe) begin
      for (int j = 0; j < int'(N_REQ); j++) begin
        cand = PTR_W'((int'(rr_ptr_q) + j) % int'(N_REQ));
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  assign rr_next        = PTR_W'((int'(grant_idx) + 1) % int'(N_REQ));
  assign grant_in_range = ({1'b0, req_addr[grant_idx]} < CELLS_EXT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StActive: if (vblank_entry) state_d = clear_pending_q ? StClear : StServe;
      StServe: begin
        if (!in_vblank)           state_d = StActive;
        else if (clear_pending_q) state_d = StClear;
      end
      StClear: begin
        if (!in_vblank)                    state_d = StActive;
        else if (clr_addr_q == LAST_ADDR)  state_d = StServe;
      end
      default: state_d = StActive;
    endcase
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) state_q <= StActive;
    else     state_q <= state_d;
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      vblank_q        <= 1'b0;
      frame_tick      <= 1'b0;
      fb_we           <= 1'b0;
      fb_addr         <= '0;
      fb_data         <= '0;
      rr_ptr_q        <= '0;
      clear_pending_q <= 1'b0;
      clr_color_q     <= '0;
      clr_addr_q      <= '0;
    end else begin
      vblank_q   <= in_vblank;
      frame_tick <= vblank_entry;
      fb_we      <= 1'b0;
      if (clr_write) begin
        fb_we      <= 1'b1;
        fb_addr    <= clr_addr_q;
        fb_data    <= clr_color_q;
        clr_addr_q <= clr_addr_q + 1'b1;
        if (clr_addr_q == LAST_ADDR) clear_pending_q <= 1'b0;
      end else if (grant_any) begin
        rr_ptr_q <= rr_next;
        // Out-of-range addresses complete the handshake but never reach the framebuffer.
        if (grant_in_range) begin
          fb_we   <= 1'b1;
          fb_addr <= req_addr[grant_idx];
          fb_data <= req_data[grant_idx];
        end
      end
      if (clear_req && !clear_pending_q) begin
        clear_pending_q <= 1'b1;
        clr_color_q     <= clear_color;
        clr_addr_q      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench for fb_write_scheduler: vector table for arbitration plus sequences
// for clear sweep, clear pause across frames and asynchronous reset.
module tb_fb_write_scheduler;

  logic        clk = 1'b0;
  logic        rst, rst_b;
  logic [9:0]  vc, vc_b;
  logic [3:0]  req_valid, req_ready, valid_b, ready_b;
  logic [12:0] req_addr [0:3];
  logic [7:0]  req_data [0:3];
  logic [12:0] addr_b [0:3];
  logic [7:0]  data_b [0:3];
  logic        clear_req, clear_busy, fb_we, frame_tick;
  logic [7:0]  clear_color, fb_data;
  logic [12:0] fb_addr;
  logic        clear_req_b, busy_b, we_b, tick_b;
  logic [7:0]  color_b, fb_data_b;
  logic [12:0] fb_addr_b;

  int n_checks = 0;
  int n_fail   = 0;
  int errs, nw;

  always #5 clk = ~clk;

  fb_write_scheduler dut (
    .vga_clk(clk), .rst(rst), .vc(vc), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(clear_busy), .fb_we(fb_we), .fb_addr(fb_addr),
    .fb_data(fb_data), .frame_tick(frame_tick)
  );

  // Short blanking window so the sweep has to pause across active video.
  fb_write_scheduler #(.VBLANK_START(520)) dut_b (
    .vga_clk(clk), .rst(rst_b), .vc(vc_b), .req_valid(valid_b), .req_addr(addr_b),
    .req_data(data_b), .req_ready(ready_b), .clear_req(clear_req_b),
    .clear_color(color_b), .clear_busy(busy_b), .fb_we(we_b), .fb_addr(fb_addr_b),
    .fb_data(fb_data_b), .frame_tick(tick_b)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [12:0] addr1;
    logic [3:0]  ready;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // requester i: addr 10*(i+1), data 8'h10+i; row field addr1 overrides requester 1
    vecs[0]  = '{4'b1000, 13'd20,   4'b1000, 1'b1, 13'd40, 8'h13};
    vecs[1]  = '{4'b1111, 13'd20,   4'b0001, 1'b1, 13'd10, 8'h10};
    vecs[2]  = '{4'b1111, 13'd20,   4'b0010, 1'b1, 13'd20, 8'h11};
    vecs[3]  = '{4'b1111, 13'd20,   4'b0100, 1'b1, 13'd30, 8'h12};
    vecs[4]  = '{4'b1111, 13'd20,   4'b1000, 1'b1, 13'd40, 8'h13};
    vecs[5]  = '{4'b1111, 13'd20,   4'b0001, 1'b1, 13'd10, 8'h10};
    vecs[6]  = '{4'b1111, 13'd4800, 4'b0010, 1'b0, 13'd10, 8'h10};
    vecs[7]  = '{4'b1111, 13'd20,   4'b0100, 1'b1, 13'd30, 8'h12};
    vecs[8]  = '{4'b0000, 13'd20,   4'b0000, 1'b0, 13'd30, 8'h12};
    vecs[9]  = '{4'b0011, 13'd20,   4'b0001, 1'b1, 13'd10, 8'h10};
    vecs[10] = '{4'b1001, 13'd20,   4'b1000, 1'b1, 13'd40, 8'h13};

    rst = 1'b1; rst_b = 1'b1; vc = '0; vc_b = '0;
    req_valid = '0; valid_b = '0; clear_req = 1'b0; clear_req_b = 1'b0;
    clear_color = '0; color_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 13'(10 * (i + 1));
      req_data[i] = 8'(8'h10 + i);
      addr_b[i]   = '0;
      data_b[i]   = '0;
    end
    #1;
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_frame_tick", 32'(frame_tick), 0);
    check("rst_clear_busy", 32'(clear_busy), 0);
    tick(); tick();
    rst = 1'b0; rst_b = 1'b0;

    // Single write held from active video into blanking
    vc = 10'd300; req_addr[2] = 13'd100; req_data[2] = 8'hE0; req_valid = 4'b0100;
    repeat (3) tick();
    check("active_ready", 32'(req_ready), 0);
    check("active_we", 32'(fb_we), 0);
    vc = 10'd480;
    tick();
    check("entry_frame_tick", 32'(frame_tick), 1);
    check("entry_ready", 32'(req_ready), 32'b0100);
    tick();
    check("single_we", 32'(fb_we), 1);
    check("single_addr", 32'(fb_addr), 100);
    check("single_data", 32'(fb_data), 32'hE0);
    check("tick_one_cycle", 32'(frame_tick), 0);
    req_valid = '0; req_addr[2] = 13'd30; req_data[2] = 8'h12;
    tick();
    check("idle_we", 32'(fb_we), 0);
    check("idle_addr_hold", 32'(fb_addr), 100);

    // Round-robin and out-of-range vectors, rr_ptr starts at 3
    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid;
      req_addr[1] = vecs[i].addr1;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      tick();
      check($sformatf("vec%0d_we", i), 32'(fb_we), 32'(vecs[i].we));
      check($sformatf("vec%0d_addr", i), 32'(fb_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d_data", i), 32'(fb_data), 32'(vecs[i].data));
    end
    req_addr[1] = 13'd20;

    // Write accepted in the last SERVE cycle still lands
    req_valid = 4'b0001; vc = 10'd0;
    #1;
    check("exit_ready_last", 32'(req_ready), 32'b0001);
    tick();
    check("exit_we", 32'(fb_we), 1);
    check("exit_addr", 32'(fb_addr), 10);
    check("exit_ready_off", 32'(req_ready), 0);
    req_valid = '0;

    // Clear sweep; second request while busy must be ignored
    vc = 10'd100;
    tick();
    clear_color = 8'h03; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clear_busy_set", 32'(clear_busy), 1);
    clear_color = 8'hFF; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    req_valid = 4'b1111; vc = 10'd480;
    tick();
    check("clr_entry_tick", 32'(frame_tick), 1);
    check("clr_entry_ready", 32'(req_ready), 0);
    check("clr_entry_we", 32'(fb_we), 0);
    errs = 0;
    for (int i = 0; i < 4800; i++) begin
      tick();
      if (fb_we !== 1'b1 || fb_addr !== 13'(i) || fb_data !== 8'h03) errs++;
      if (i < 4799 && (req_ready !== 4'b0000 || clear_busy !== 1'b1)) errs++;
    end
    check("clear_sweep_errs", 32'(errs), 0);
    check("clear_busy_fall", 32'(clear_busy), 0);
    check("post_clear_ready", 32'(req_ready), 32'b0010);
    tick();
    check("post_clear_addr", 32'(fb_addr), 20);
    check("post_clear_data", 32'(fb_data), 32'h11);

    // clear_req together with a requester in SERVE: transfer first, then CLEAR
    req_valid = 4'b0100; clear_req = 1'b1; clear_color = 8'hA5;
    #1;
    check("both_ready", 32'(req_ready), 32'b0100);
    tick();
    clear_req = 1'b0; req_valid = '0;
    check("both_we", 32'(fb_we), 1);
    check("both_addr", 32'(fb_addr), 30);
    check("both_busy", 32'(clear_busy), 1);
    tick();
    req_valid = 4'b1111;
    #1;
    check("both_clear_ready", 32'(req_ready), 0);
    check("both_clear_gap", 32'(fb_we), 0);
    tick();
    check("both_first_addr", 32'(fb_addr), 0);
    check("both_first_data", 32'(fb_data), 32'hA5);
    repeat (9) tick();
    check("midsweep_addr", 32'(fb_addr), 9);

    // Asynchronous reset mid-sweep
    #2 rst = 1'b1;
    #1;
    check("arst_we", 32'(fb_we), 0);
    check("arst_addr", 32'(fb_addr), 0);
    check("arst_data", 32'(fb_data), 0);
    check("arst_busy", 32'(clear_busy), 0);
    check("arst_ready", 32'(req_ready), 0);
    tick();
    rst = 1'b0; req_valid = '0;
    nw = 0;
    repeat (20) begin tick(); if (fb_we) nw++; end
    vc = 10'd0;
    repeat (3) begin tick(); if (fb_we) nw++; end
    vc = 10'd480;
    tick();
    check("rst_next_frame_tick", 32'(frame_tick), 1);
    check("rst_next_busy", 32'(clear_busy), 0);
    repeat (10) begin tick(); if (fb_we) nw++; end
    check("rst_no_writes", 32'(nw), 0);

    // Clear pause on the short-blanking instance
    vc_b = 10'd100;
    tick();
    color_b = 8'h1C; clear_req_b = 1'b1;
    tick();
    clear_req_b = 1'b0; vc_b = 10'd520;
    tick();
    check("pause_entry_tick", 32'(tick_b), 1);
    check("pause_entry_we", 32'(we_b), 0);
    errs = 0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (we_b !== 1'b1 || fb_addr_b !== 13'(i) || fb_data_b !== 8'h1C) errs++;
      if (ready_b !== 4'b0000) errs++;
    end
    check("pause_seg1_errs", 32'(errs), 0);
    check("pause_seg1_busy", 32'(busy_b), 1);
    vc_b = 10'd0;
    tick();
    check("pause_stop_we", 32'(we_b), 0);
    check("pause_busy_held", 32'(busy_b), 1);
    nw = 0;
    repeat (60) begin tick(); if (we_b) nw++; end
    vc_b = 10'd519;
    repeat (20) begin tick(); if (we_b) nw++; end
    check("pause_no_writes", 32'(nw), 0);
    vc_b = 10'd520;
    tick();
    check("resume_tick", 32'(tick_b), 1);
    check("resume_entry_we", 32'(we_b), 0);
    errs = 0;
    for (int i = 4000; i < 4800; i++) begin
      tick();
      if (we_b !== 1'b1 || fb_addr_b !== 13'(i) || fb_data_b !== 8'h1C) errs++;
    end
    check("pause_seg2_errs", 32'(errs), 0);
    check("pause_done_busy", 32'(busy_b), 0);
    tick();
    check("pause_done_we", 32'(we_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Schedules all writes into the 80x60 character-cell framebuffer so that they occur only during vertical blanking. Sits between the game logic and the framebuffer write port. The VGA timing generator supplies `vc`, and the scan-out side never sees a mid-frame update. The block round-robin arbitrates four write requesters with valid/ready handshakes. It also provides a full-screen clear sweep that takes priority over the requesters and pauses across frames when blanking ends.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters.
- `ADDR_W`, 13: cell address width.
- `CELLS`, 4800: cell count (80x60); valid addresses are 0..CELLS-1.
- `VBLANK_START`, 480: first `vc` value of vertical blanking.

Ports:
- `vga_clk`, in, 1: single clock; one clock, the same clock as the VGA timing generator.
- `rst`, in, 1: reset, asynchronous, active-high.
- `vc`, in, 10: vertical counter from VGA timing, 0..524.
- `req_valid`, in, N_REQ: per-requester write request.
- `req_addr`, in, ADDR_W x N_REQ (unpacked `[0:N_REQ-1]`): cell address.
- `req_data`, in, 8 x N_REQ: color RRRGGGBB.
- `req_ready`, out, N_REQ: grant; one-hot or zero.
- `clear_req`, in, 1: pulse requesting a full clear.
- `clear_color`, in, 8: color captured with `clear_req`.
- `clear_busy`, out, 1: clear pending or in progress.
- `fb_we`, out, 1: framebuffer write enable, registered.
- `fb_addr`, out, ADDR_W: write address, registered.
- `fb_data`, out, 8: write data, registered.
- `frame_tick`, out, 1: one-cycle pulse at vblank entry, registered.

## Operation
- `vblank_q` is registered `(vc >= VBLANK_START)`.
- `frame_tick` is registered `(vc >= VBLANK_START) && !vblank_q`.
- FSM states: ACTIVE, SERVE, CLEAR. Reset state is ACTIVE.
  - ACTIVE -> CLEAR: on the edge where `frame_tick` is set, if `clear_pending`.
  - ACTIVE -> SERVE: on that same edge otherwise.
  - SERVE -> CLEAR: if `clear_pending` (a request arrived during blanking).
  - SERVE -> ACTIVE: when `vc < VBLANK_START` is sampled.
  - CLEAR -> SERVE: after writing address CELLS-1, if still in blanking.
  - CLEAR -> ACTIVE: after writing address CELLS-1 if blanking has ended, or immediately when blanking ends with the sweep incomplete (pause).
- Pause:
  - `clr_addr` is retained while paused.
  - `clear_pending` stays set while paused.
  - The next vblank entry re-enters CLEAR and resumes at `clr_addr`.
- Clear request handling:
  - `clear_req` while `clear_busy` = 0: sets `clear_pending`, latches `clear_color`, resets `clr_addr` to 0.
  - `clear_req` while `clear_busy` = 1: ignored.
  - `clear_busy` = `clear_pending`.
  - `clear_pending` is cleared on the edge that writes CELLS-1.
- `req_ready` is combinational:
  - Nonzero only in SERVE.
  - Grants the first valid requester at or after `rr_ptr`, wrapping modulo N_REQ.
  - Zero in ACTIVE and CLEAR.
- Transfer handling:
  - A transfer is `req_valid[i] && req_ready[i]`.
  - On a transfer, the next edge sets `fb_we`=1, `fb_addr`=`req_addr[i]`, `fb_data`=`req_data[i]`, and `rr_ptr`=(i+1) mod N_REQ.
  - A transfer with `req_addr` >= CELLS is accepted but dropped: `fb_we`=0, and `rr_ptr` still advances.
- In CLEAR, each edge sets `fb_we`=1, `fb_addr`=`clr_addr`, `fb_data`=latched color, then increments `clr_addr`.
- In every other cycle `fb_we`=0; `fb_addr` and `fb_data` hold their values.
- Reset, including mid-sweep:
  - Outputs: `fb_we`=0, `fb_addr`=0, `fb_data`=0, `frame_tick`=0, `clear_busy`=0, `req_ready`=0.
  - Internal: `vblank_q`=0, `rr_ptr`=0, `clr_addr`=0, state ACTIVE.
  - No partial clear survives reset.

## Timing
- Edge k is the first edge sampling `vc`=VBLANK_START. After edge k, `frame_tick`=1 for exactly one cycle and the state is SERVE or CLEAR.
- SERVE:
  - `req_ready` can assert in the cycle after edge k.
  - Throughput is one write per cycle.
  - Latency is one edge from handshake to `fb_we`.
- CLEAR from vblank entry:
  - Address 0 is written after edge k+1.
  - Address CELLS-1 is written after edge k+CELLS.
  - The default parameters give 36000 blanking cycles, so a sweep never pauses.
- Blanking exit:
  - The first edge sampling `vc` < VBLANK_START moves the state to ACTIVE.
  - `req_ready` is 0 from the next cycle.
  - A write accepted in the last SERVE cycle still appears on `fb_*` after that edge.
- `clear_req` and a requester valid in the same SERVE cycle: the requester transfer completes, and CLEAR begins on the next edge.

## Test plan
- **Reset:** assert `rst` asynchronously mid-clear -> all outputs 0 immediately; `clear_busy`=0; no `fb_we` until the next vblank after release.
- **Single write:** drive `req_valid[2]`, addr 100, data 8'hE0, while `vc`=300 -> `req_ready`=0 until `vc`=480. `req_ready[2]` asserts the cycle after `frame_tick`; next edge gives `fb_we`=1, `fb_addr`=100, `fb_data`=8'hE0.
- **Round-robin:** all 4 requesters valid during vblank from `rr_ptr`=0 -> grants 0,1,2,3,0 on consecutive cycles; each `fb_addr` matches the granted requester.
- **Out-of-range address:** requester 1 with addr 4800 -> handshake completes, `fb_we` stays 0, next grant goes to requester 2.
- **Clear sweep:** pulse `clear_req` with `clear_color`=8'h03 at `vc`=100 -> at vblank, exactly 4800 consecutive writes, addresses 0..4799, data 8'h03. `req_ready`=0 throughout, then SERVE; `clear_busy` falls with the last write.
- **Clear pause:** set VBLANK_START=520 (4000 blanking cycles), then `clear_req` -> addresses 0..3999 are written, the sweep pauses through active video, 4000..4799 are written at the next vblank, and there is no `fb_we` while `vc` < 520.
